// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch constants (instruction width, PC increment, NOP encoding)
package fetch_unit_pkg;
  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with push/pop/flush/count, async active-high reset
module fetch_queue #(
  parameter int W = 32,
  parameter int DEPTH = 2,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-limited imem requests, in-order decode queue, redirect flush; FETCH_MISALIGN_CHECK_EN enables misaligned-redirect fault
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [31:0]        dec_pc,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               fetch_fault,
  output logic [31:0]        fault_pc
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int DW = $clog2(2 * QUEUE_DEPTH + 1);
  logic [31:0] pc, pcq_dout;
  logic [DW-1:0] discard_cnt;
  logic [CW-1:0] live_cnt, occ;
  logic [INSTR_W+31:0] iq_dout;
  logic grant, accept;
  assign grant = imem_req && imem_gnt;
  assign accept = imem_rvalid && discard_cnt == '0;
  assign imem_addr = pc;
  assign imem_req = !rst && !fetch_fault && !redirect_valid && ({1'b0, live_cnt} + {1'b0, occ}) < (CW + 1)'(QUEUE_DEPTH);
  assign dec_valid = occ != '0 && !redirect_valid;
  assign dec_instr = iq_dout[INSTR_W+31:32];
  assign dec_pc = iq_dout[31:0];
  fetch_queue #(.W(32), .DEPTH(QUEUE_DEPTH)) u_pcq (
    .clk(clk), .rst(rst), .push(grant), .pop(accept), .flush(redirect_valid),
    .din(pc), .dout(pcq_dout), .count(live_cnt)
  );
  fetch_queue #(.W(INSTR_W + 32), .DEPTH(QUEUE_DEPTH)) u_iq (
    .clk(clk), .rst(rst), .push(accept && !redirect_valid), .pop(dec_valid && dec_ready),
    .flush(redirect_valid), .din({imem_rdata, pcq_dout}), .dout(iq_dout), .count(occ)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      discard_cnt <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~32'h3;
      discard_cnt <= discard_cnt + DW'(live_cnt) + DW'(grant) - DW'(imem_rvalid);
    end else begin
      if (grant) pc <= pc + PC_INC;
      if (imem_rvalid && discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
    end
  end
`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_fault <= 1'b0;
      fault_pc <= '0;
    end else if (redirect_valid) begin
      fetch_fault <= |redirect_pc[1:0];
      if (|redirect_pc[1:0]) fault_pc <= redirect_pc;
    end
  end
`else
  assign fetch_fault = 1'b0;
  assign fault_pc = '0;
`endif
  a_rvalid_tracked: assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> (live_cnt != '0 || discard_cnt != '0));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit with a latency memory model and program-order scoreboard
module tb_fetch_unit;
  logic clk = 0, rst = 1;
  logic imem_req, imem_gnt = 0, imem_rvalid = 0, dec_valid, dec_ready = 0, redirect_valid = 0, fetch_fault;
  logic [31:0] imem_addr, imem_rdata = 0, dec_instr, dec_pc, redirect_pc = 0, fault_pc;
  typedef struct {logic [31:0] data; int due;} resp_t;
  resp_t mq[$];
  logic [31:0] gq[$], dq[$];
  logic [31:0] exp_addr, exp_pc;
  int tests = 0, fails = 0, cyc = 0, lat = 1, last_due = 0;
  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );
  always #5 clk = ~clk;
  task automatic mem_reset();
    mq.delete();
    last_due = 0;
    exp_addr = 0;
    exp_pc = 0;
  endtask
  task automatic step(input logic g, input logic rdy, input logic rd, input logic [31:0] rpc);
    int due;
    @(negedge clk);
    imem_gnt = g;
    dec_ready = rdy;
    redirect_valid = rd;
    redirect_pc = rpc;
    imem_rvalid = mq.size() > 0 && mq[0].due <= cyc;
    imem_rdata = imem_rvalid ? mq[0].data : 32'h0;
    #1;
    if (rd) begin
      tests++;
      if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin
        fails++;
        $display("FAIL redirect_cycle: dec_valid=%b imem_req=%b want 0 0", dec_valid, imem_req);
      end
    end
    if (imem_req && imem_gnt) begin
      tests++;
      if (imem_addr !== exp_addr) begin
        fails++;
        $display("FAIL grant_addr: got %h want %h", imem_addr, exp_addr);
      end
      gq.push_back(imem_addr);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{imem_addr + 32'd1000, due});
      exp_addr = exp_addr + 4;
    end
    if (dec_valid && dec_ready) begin
      tests++;
      if (dec_pc !== exp_pc || dec_instr !== exp_pc + 32'd1000) begin
        fails++;
        $display("FAIL decode: pc=%h instr=%h want pc=%h instr=%h", dec_pc, dec_instr, exp_pc, exp_pc + 32'd1000);
      end
      dq.push_back(dec_pc);
      exp_pc = exp_pc + 4;
    end
    if (imem_rvalid) void'(mq.pop_front());
    if (rd) begin
      exp_addr = rpc & ~32'h3;
      exp_pc = rpc & ~32'h3;
    end
    cyc++;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({imem_req, dec_valid, fetch_fault} !== 3'b000 || dec_instr !== 0 || dec_pc !== 0 || fault_pc !== 0) begin
      fails++;
      $display("FAIL reset: req=%b dv=%b ff=%b instr=%h pc=%h fpc=%h want all 0", imem_req, dec_valid, fetch_fault, dec_instr, dec_pc, fault_pc);
    end
    @(negedge clk);
    rst = 0;
    mem_reset();
    cyc = 0;
  endtask
  task automatic test_stream();
    int first = -1;
    lat = 1;
    for (int k = 0; k < 30; k++) begin
      step(1, 1, 0, 0);
      if (k == 0) begin
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
          fails++;
          $display("FAIL first_req: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
        end
      end
      if (dec_valid && first < 0) first = k;
    end
    tests++;
    if (first != 2) begin
      fails++;
      $display("FAIL fill_latency: first dec_valid cycle %0d want 2", first);
    end
    tests++;
    if (gq.size() < 3 || gq[0] !== 0 || gq[1] !== 4 || gq[2] !== 8) begin
      fails++;
      $display("FAIL addr_seq: grants=%0d want 0,4,8", gq.size());
    end
    tests++;
    if (dq.size() < 10 || dq[0] !== 0) begin
      fails++;
      $display("FAIL stream_count: decoded %0d want >=10 starting at 0", dq.size());
    end
  endtask
  task automatic test_stall();
    int g0, d0;
    step(1, 0, 1, 32'h40);
    g0 = gq.size();
    repeat (10) step(1, 0, 0, 0);
    tests++;
    if (gq.size() - g0 != 2 || imem_req !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== 32'h40) begin
      fails++;
      $display("FAIL stall: grants=%0d req=%b dv=%b pc=%h want 2 0 1 00000040", gq.size() - g0, imem_req, dec_valid, dec_pc);
    end
    d0 = dq.size();
    repeat (10) step(1, 1, 0, 0);
    tests++;
    if (dq.size() - d0 < 4 || dq[d0] !== 32'h40 || dq[d0+1] !== 32'h44) begin
      fails++;
      $display("FAIL stall_release: delivered %0d want >=4 from 00000040", dq.size() - d0);
    end
  endtask
  task automatic test_redirect_latency();
    int d0;
    lat = 3;
    step(1, 1, 1, 32'h80);
    for (int i = 0; i < 20 && mq.size() < 2; i++) step(1, 1, 0, 0);
    tests++;
    if (mq.size() != 2) begin
      fails++;
      $display("FAIL outstanding: got %0d want 2", mq.size());
    end
    d0 = dq.size();
    step(1, 1, 1, 32'h100);
    step(1, 1, 0, 0);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      fails++;
      $display("FAIL redirect_req: req=%b addr=%h want 1 00000100", imem_req, imem_addr);
    end
    repeat (15) step(1, 1, 0, 0);
    tests++;
    if (dq.size() <= d0 || dq[d0] !== 32'h100) begin
      fails++;
      $display("FAIL redirect_first: decoded %0d after redirect, want first pc 00000100", dq.size() - d0);
    end
  endtask
  task automatic test_collide();
    int d0;
    logic found = 0;
    lat = 2;
    step(1, 1, 1, 32'h200);
    for (int i = 0; i < 20 && !found; i++) begin
      if (i > 2 && mq.size() > 0 && mq[0].due <= cyc) begin
        d0 = dq.size();
        step(1, 1, 1, 32'h300);
        found = 1;
      end else step(1, 1, 0, 0);
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL collide_setup: no response lined up, got 0 want 1");
    end
    repeat (15) step(1, 1, 0, 0);
    tests++;
    if (!found || dq.size() <= d0 || dq[d0] !== 32'h300) begin
      fails++;
      $display("FAIL collide_first: decoded %0d after redirect, want first pc 00000300", found ? dq.size() - d0 : 0);
    end
  endtask
  task automatic test_wrap();
    int g0;
    lat = 1;
    g0 = gq.size();
    step(1, 1, 1, 32'hFFFF_FFF8);
    repeat (12) step(1, 1, 0, 0);
    tests++;
    if (gq.size() < g0 + 3 || gq[g0] !== 32'hFFFF_FFF8 || gq[g0+1] !== 32'hFFFF_FFFC || gq[g0+2] !== 32'h0) begin
      fails++;
      $display("FAIL wrap: got %0d grants after redirect, want FFFFFFF8,FFFFFFFC,00000000", gq.size() - g0);
    end
  endtask
  task automatic test_random();
    int d0 = dq.size();
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 4);
      step($urandom % 4 != 0, $urandom % 3 != 0, $urandom_range(0, 24) == 0, $urandom & ~32'h3);
    end
    tests++;
    if (dq.size() - d0 < 40) begin
      fails++;
      $display("FAIL random_progress: decoded %0d want >=40", dq.size() - d0);
    end
  endtask
  task automatic test_misalign();
    int g0;
    lat = 1;
`ifdef FETCH_MISALIGN_CHECK_EN
    step(1, 1, 1, 32'h102);
    g0 = gq.size();
    step(1, 1, 0, 0);
    tests++;
    if (fetch_fault !== 1'b1 || fault_pc !== 32'h102 || imem_req !== 1'b0) begin
      fails++;
      $display("FAIL fault_set: ff=%b fpc=%h req=%b want 1 00000102 0", fetch_fault, fault_pc, imem_req);
    end
    repeat (5) step(1, 1, 0, 0);
    tests++;
    if (gq.size() != g0 || fetch_fault !== 1'b1) begin
      fails++;
      $display("FAIL fault_hold: grants=%0d ff=%b want 0 1", gq.size() - g0, fetch_fault);
    end
    step(1, 1, 1, 32'h200);
    step(1, 1, 0, 0);
    tests++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      fails++;
      $display("FAIL fault_clear: ff=%b req=%b addr=%h want 0 1 00000200", fetch_fault, imem_req, imem_addr);
    end
`else
    step(1, 1, 1, 32'h102);
    g0 = gq.size();
    step(1, 1, 0, 0);
    tests++;
    if (fetch_fault !== 1'b0 || fault_pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h100 || gq.size() != g0 + 1) begin
      fails++;
      $display("FAIL misalign_ignored: ff=%b fpc=%h req=%b addr=%h want 0 0 1 00000100", fetch_fault, fault_pc, imem_req, imem_addr);
    end
`endif
    repeat (8) step(1, 1, 0, 0);
  endtask
  task automatic test_async_reset();
    int d0;
    lat = 2;
    repeat (5) step(1, 1, 0, 0);
    @(negedge clk);
    #3 rst = 1;
    #1;
    tests++;
    if (imem_req !== 1'b0 || dec_valid !== 1'b0 || dec_pc !== 0 || dec_instr !== 0 || fetch_fault !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: req=%b dv=%b pc=%h instr=%h ff=%b want all 0", imem_req, dec_valid, dec_pc, dec_instr, fetch_fault);
    end
    {imem_gnt, imem_rvalid, dec_ready, redirect_valid} = 4'b0;
    mem_reset();
    @(negedge clk);
    rst = 0;
    d0 = dq.size();
    repeat (12) step(1, 1, 0, 0);
    tests++;
    if (dq.size() <= d0 || dq[d0] !== 32'h0) begin
      fails++;
      $display("FAIL post_reset: decoded %0d, want first pc 00000000", dq.size() - d0);
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_latency();
    test_collide();
    test_wrap();
    test_random();
    test_misalign();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
